// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture sequencer.
// Holds the FSM encoding, default widths and the sample sign conversion.
package adc_capture_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_OVF_W  = 16;

  // Widest sample the sign helper can process; callers truncate the result.
  localparam int SIGN_FLIP_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Offset-binary to two's complement: flip bit (width-1) when en is set.
  function automatic logic [SIGN_FLIP_MAX_W-1:0] sign_flip(
    input logic [SIGN_FLIP_MAX_W-1:0] data,
    input int unsigned                width,
    input logic                       en
  );
    return data ^ (64'(en) << (width - 32'd1));
  endfunction

endpackage

// File: rtl/adc_capture_sequencer_axis_hold_stage.sv
// Single-entry AXI-Stream output register.
// Loads only when free; holds TDATA/TLAST stable while stalled.
module axis_hold_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last,
  output logic              free
);

  // Free when empty or when the held beat transfers this cycle.
  assign free = ~valid | ready;

  // Beat register: load wins, a transfer without load empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else begin
      data  <= data;
      valid <= valid;
      last  <= last;
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Captures a fixed-length burst of ADC samples and streams it as one AXIS packet.
// Samples arriving while the output stage is blocked are dropped and counted.
module adc_capture_sequencer
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int OVF_W  = DEF_OVF_W
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              Start_i,
  input  logic              Abort_i,
  input  logic [LEN_W-1:0]  FrameLen_i,
  input  logic              InvertSign_i,
  input  logic [DATA_W-1:0] AdcData_i,
  input  logic              AdcValid_i,
  output logic [DATA_W-1:0] M_AXIS_TDATA_o,
  output logic              M_AXIS_TVALID_o,
  input  logic              M_AXIS_TREADY_i,
  output logic              M_AXIS_TLAST_o,
  output logic              Busy_o,
  output logic              Done_o,
  output logic              Aborted_o,
  output logic [OVF_W-1:0]  OvfCnt_o
);

  state_t             state, state_next;
  logic [LEN_W-1:0]   frame_len, frame_len_next;
  logic [LEN_W-1:0]   count, count_next;
  logic [OVF_W-1:0]   ovf_cnt, ovf_cnt_next;
  logic               invert, invert_next;
  logic               abort_pend, abort_pend_next;
  logic               abort_frame, abort_frame_next;
  logic               done, done_next;
  logic               aborted, aborted_next;
  logic               busy, busy_next;
  logic               hold_free;
  logic               load;
  logic               load_last;
  logic               abort_now;
  logic               final_sample;
  logic [DATA_W-1:0]  conv_data;

  assign conv_data    = DATA_W'(sign_flip(64'(AdcData_i), DATA_W, invert));
  assign abort_now    = Abort_i | abort_pend;
  assign final_sample = (count == (frame_len - 1'b1));

  axis_hold_stage #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (Clk_i),
    .rst       (Rst_i),
    .load      (load),
    .load_data (conv_data),
    .load_last (load_last),
    .ready     (M_AXIS_TREADY_i),
    .data      (M_AXIS_TDATA_o),
    .valid     (M_AXIS_TVALID_o),
    .last      (M_AXIS_TLAST_o),
    .free      (hold_free)
  );

  // Control and counter registers.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state       <= IDLE;
      frame_len   <= '0;
      count       <= '0;
      ovf_cnt     <= '0;
      invert      <= 1'b0;
      abort_pend  <= 1'b0;
      abort_frame <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      frame_len   <= frame_len_next;
      count       <= count_next;
      ovf_cnt     <= ovf_cnt_next;
      invert      <= invert_next;
      abort_pend  <= abort_pend_next;
      abort_frame <= abort_frame_next;
      done        <= done_next;
      aborted     <= aborted_next;
      busy        <= busy_next;
    end
  end

  // Next-state, counters and load requests for the hold stage.
  always_comb begin
    state_next       = state;
    frame_len_next   = frame_len;
    count_next       = count;
    ovf_cnt_next     = ovf_cnt;
    invert_next      = invert;
    abort_pend_next  = abort_pend;
    abort_frame_next = abort_frame;
    done_next        = 1'b0;
    aborted_next     = 1'b0;
    load             = 1'b0;
    load_last        = 1'b0;

    case (state)
      IDLE: begin
        if (Start_i && (FrameLen_i != '0)) begin
          state_next       = CAPTURE;
          frame_len_next   = FrameLen_i;
          invert_next      = InvertSign_i;
          count_next       = '0;
          ovf_cnt_next     = '0;
          abort_pend_next  = 1'b0;
          abort_frame_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end

      CAPTURE: begin
        if (abort_now && (count == '0) && !M_AXIS_TVALID_o) begin
          // Nothing was emitted yet, so there is no packet to terminate.
          state_next      = IDLE;
          aborted_next    = 1'b1;
          abort_pend_next = 1'b0;
        end else if (AdcValid_i && hold_free) begin
          load       = 1'b1;
          load_last  = final_sample | abort_now;
          count_next = count + 1'b1;
          if (final_sample || abort_now) begin
            // A concurrent abort on the final sample still yields a complete frame.
            state_next       = FLUSH;
            abort_frame_next = ~final_sample;
            abort_pend_next  = 1'b0;
          end else begin
            abort_pend_next = 1'b0;
          end
        end else begin
          abort_pend_next = abort_now;
          if (AdcValid_i && (ovf_cnt != '1)) begin
            ovf_cnt_next = ovf_cnt + 1'b1;
          end else begin
            ovf_cnt_next = ovf_cnt;
          end
        end
      end

      FLUSH: begin
        if (M_AXIS_TVALID_o && M_AXIS_TREADY_i) begin
          state_next   = IDLE;
          done_next    = ~abort_frame;
          aborted_next = abort_frame;
        end else begin
          state_next = FLUSH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign Busy_o    = busy;
  assign Done_o    = done;
  assign Aborted_o = aborted;
  assign OvfCnt_o  = ovf_cnt;

endmodule
